// File: rtl/bus_pkg.sv
// Shared types and constants for the CPU-side byte bus router.
// Holds the FSM encoding, bus width defaults and region-table slicing helpers.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } bus_state_t;

  localparam int         BUS_AW           = 20;
  localparam int         BUS_DW           = 8;
  localparam logic [7:0] BUS_DEFAULT_DATA = 8'hFF;

  // Region tables are zero-extended to a fixed container so one helper serves any width.
  localparam int TBL_MAX_CH = 8;
  localparam int TBL_MAX_W  = 32;
  localparam int TBL_W      = TBL_MAX_CH * TBL_MAX_W;

  typedef logic [TBL_W-1:0]     region_tbl_t;
  typedef logic [TBL_MAX_W-1:0] region_fld_t;

  function automatic region_fld_t region_field(input region_tbl_t tbl,
                                               input int unsigned idx,
                                               input int unsigned w);
    region_tbl_t shifted;
    region_fld_t keep;
    shifted = tbl >> (idx * w);
    keep    = (w >= TBL_MAX_W) ? '1 : ((region_fld_t'(1) << w) - region_fld_t'(1));
    return region_fld_t'(shifted) & keep;
  endfunction

endpackage

// File: rtl/bus_decode.sv
// Address decode: base/mask match per channel, lowest index wins on overlap.
// Latency: purely combinational.
// Backpressure: none; outputs follow the address input.
module bus_decode
  import bus_pkg::*;
#(
  parameter int                      CHANNELS    = 4,
  parameter int                      AW          = BUS_AW,
  parameter int                      IW          = 2,
  parameter logic [CHANNELS*AW-1:0]  REGION_BASE = '0,
  parameter logic [CHANNELS*AW-1:0]  REGION_MASK = '0,
  parameter logic [CHANNELS*4-1:0]   REGION_WAIT = '0,
  parameter logic [CHANNELS-1:0]     REGION_RO   = '0
) (
  input  logic [AW-1:0]       address,
  output logic [CHANNELS-1:0] hit,
  output logic [IW-1:0]       index,
  output logic                ro,
  output logic [3:0]          wait_cycles,
  output logic                unmapped
);

  localparam region_tbl_t BASE_T = region_tbl_t'(REGION_BASE);
  localparam region_tbl_t MASK_T = region_tbl_t'(REGION_MASK);
  localparam region_tbl_t WAIT_T = region_tbl_t'(REGION_WAIT);
  localparam region_tbl_t RO_T   = region_tbl_t'(REGION_RO);

  always_comb begin
    hit         = '0;
    index       = '0;
    ro          = 1'b0;
    wait_cycles = '0;
    unmapped    = 1'b1;
    // Ascending scan; the first match closes the search so lower indices take priority.
    for (int i = 0; i < CHANNELS; i++) begin
      if (unmapped &&
          ((address & AW'(region_field(MASK_T, i, AW))) == AW'(region_field(BASE_T, i, AW)))) begin
        unmapped    = 1'b0;
        hit         = CHANNELS'(1) << i;
        index       = IW'(i);
        ro          = 1'(region_field(RO_T, i, 1));
        wait_cycles = 4'(region_field(WAIT_T, i, 4));
      end
    end
  end

endmodule

// File: rtl/bus_router.sv
// Routes one CPU byte bus to CHANNELS decoded memory/peripheral channels.
// Latency: WAIT[i]+2 cycles per mapped access, 1 cycle for unmapped addresses.
// Backpressure: cpu_req held until cpu_ready; one forced idle cycle after each completion.
module bus_router
  import bus_pkg::*;
#(
  parameter int                      CHANNELS     = 4,
  parameter int                      AW           = BUS_AW,
  parameter int                      DW           = BUS_DW,
  parameter logic [CHANNELS*AW-1:0]  REGION_BASE  = {20'hF0000, 20'h00000, 20'hB8000, 20'h00000},
  parameter logic [CHANNELS*AW-1:0]  REGION_MASK  = {20'hFE000, 20'hC0000, 20'hFE000, 20'hFF000},
  parameter logic [CHANNELS*4-1:0]   REGION_WAIT  = {4'd1, 4'd0, 4'd0, 4'd0},
  parameter logic [CHANNELS-1:0]     REGION_RO    = 4'b1000,
  parameter logic [DW-1:0]           DEFAULT_DATA = DW'(BUS_DEFAULT_DATA)
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [AW-1:0]          cpu_address,
  input  logic [DW-1:0]          cpu_wdata,
  output logic [DW-1:0]          cpu_rdata,
  output logic                   cpu_ready,
  output logic                   cpu_err,
  output logic [AW-1:0]          ch_address,
  output logic [DW-1:0]          ch_wdata,
  output logic [CHANNELS-1:0]    ch_sel,
  output logic [CHANNELS-1:0]    ch_we,
  input  logic [CHANNELS*DW-1:0] ch_rdata
);

  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0] dec_hit;
  logic [IW-1:0]       dec_index;
  logic                dec_ro;
  logic [3:0]          dec_wait;
  logic                dec_unmapped;

  bus_decode #(
    .CHANNELS    (CHANNELS),
    .AW          (AW),
    .IW          (IW),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK),
    .REGION_WAIT (REGION_WAIT),
    .REGION_RO   (REGION_RO)
  ) u_decode (
    .address     (cpu_address),
    .hit         (dec_hit),
    .index       (dec_index),
    .ro          (dec_ro),
    .wait_cycles (dec_wait),
    .unmapped    (dec_unmapped)
  );

  bus_state_t          state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic [IW-1:0]       cur_idx, cur_idx_nxt;
  logic                ro_write, ro_write_nxt;
  logic [AW-1:0]       ch_address_nxt;
  logic [DW-1:0]       ch_wdata_nxt;
  logic [CHANNELS-1:0] ch_sel_nxt;
  logic [CHANNELS-1:0] ch_we_nxt;
  logic [DW-1:0]       cpu_rdata_nxt;
  logic                cpu_ready_nxt;
  logic                cpu_err_nxt;
  logic [DW-1:0]       sel_rdata;

  assign sel_rdata = DW'(ch_rdata >> (int'(cur_idx) * DW));

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    cur_idx_nxt    = cur_idx;
    ro_write_nxt   = ro_write;
    ch_address_nxt = ch_address;
    ch_wdata_nxt   = ch_wdata;
    ch_sel_nxt     = ch_sel;
    ch_we_nxt      = '0;
    cpu_rdata_nxt  = cpu_rdata;
    cpu_ready_nxt  = 1'b0;
    cpu_err_nxt    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cpu_req) begin
          if (dec_unmapped) begin
            cpu_rdata_nxt = DEFAULT_DATA;
            cpu_ready_nxt = 1'b1;
            cpu_err_nxt   = 1'b1;
            state_nxt     = ST_DONE;
          end else begin
            ch_address_nxt = cpu_address;
            ch_wdata_nxt   = cpu_wdata;
            ch_sel_nxt     = dec_hit;
            cnt_nxt        = dec_wait;
            cur_idx_nxt    = dec_index;
            // A write into a read-only region still runs its full access, minus the strobe.
            ro_write_nxt   = cpu_we & dec_ro;
            ch_we_nxt      = (cpu_we && !dec_ro) ? dec_hit : '0;
            state_nxt      = ST_ACCESS;
          end
        end
      end

      ST_ACCESS: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          cpu_rdata_nxt = sel_rdata;
          cpu_ready_nxt = 1'b1;
          cpu_err_nxt   = ro_write;
          ch_sel_nxt    = '0;
          state_nxt     = ST_DONE;
        end
      end

      ST_DONE: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      cur_idx    <= '0;
      ro_write   <= 1'b0;
      ch_address <= '0;
      ch_wdata   <= '0;
      ch_sel     <= '0;
      ch_we      <= '0;
      cpu_rdata  <= DEFAULT_DATA;
      cpu_ready  <= 1'b0;
      cpu_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      cur_idx    <= cur_idx_nxt;
      ro_write   <= ro_write_nxt;
      ch_address <= ch_address_nxt;
      ch_wdata   <= ch_wdata_nxt;
      ch_sel     <= ch_sel_nxt;
      ch_we      <= ch_we_nxt;
      cpu_rdata  <= cpu_rdata_nxt;
      cpu_ready  <= cpu_ready_nxt;
      cpu_err    <= cpu_err_nxt;
    end
  end

endmodule

// File: tb/tb_bus_router.sv
// Directed plus randomised checks of bus_router against a region-table reference model.
module tb_bus_router;

  localparam int CH = 4;
  localparam int AW = 20;
  localparam int DW = 8;

  logic             clock = 1'b0;
  logic             resetn;
  logic             cpu_req;
  logic             cpu_we;
  logic [AW-1:0]    cpu_address;
  logic [DW-1:0]    cpu_wdata;
  logic [DW-1:0]    cpu_rdata;
  logic             cpu_ready;
  logic             cpu_err;
  logic [AW-1:0]    ch_address;
  logic [DW-1:0]    ch_wdata;
  logic [CH-1:0]    ch_sel;
  logic [CH-1:0]    ch_we;
  logic [CH*DW-1:0] ch_rdata;

  always #5 clock = ~clock;

  bus_router #(
    .CHANNELS     (CH),
    .AW           (AW),
    .DW           (DW),
    .REGION_BASE  ({20'hF0000, 20'h00000, 20'hB8000, 20'h00000}),
    .REGION_MASK  ({20'hFE000, 20'hC0000, 20'hFE000, 20'hFF000}),
    .REGION_WAIT  ({4'd1, 4'd0, 4'd0, 4'd2}),
    .REGION_RO    (4'b1000),
    .DEFAULT_DATA (8'hFF)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_address (cpu_address),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ready   (cpu_ready),
    .cpu_err     (cpu_err),
    .ch_address  (ch_address),
    .ch_wdata    (ch_wdata),
    .ch_sel      (ch_sel),
    .ch_we       (ch_we),
    .ch_rdata    (ch_rdata)
  );

  // Reference region table, channel 0 first.
  int unsigned m_base [CH] = '{32'h00000, 32'hB8000, 32'h00000, 32'hF0000};
  int unsigned m_mask [CH] = '{32'hFF000, 32'hFE000, 32'hC0000, 32'hFE000};
  int unsigned m_wait [CH] = '{2, 0, 0, 1};
  bit          m_ro   [CH] = '{1'b0, 1'b0, 1'b0, 1'b1};

  int n_pass  = 0;
  int n_total = 0;

  function automatic int model_ch(input logic [AW-1:0] a);
    for (int i = 0; i < CH; i++)
      if ((32'(a) & m_mask[i]) == m_base[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Called and returns at a negedge; checks every cycle of one access plus the gap after it.
  task automatic run_txn(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                         input bit wiggle, input bit hold);
    int            ch;
    int            lat;
    int            n;
    bit            got;
    logic [CH-1:0] exp_oh;
    logic [CH-1:0] exp_we;
    logic [DW-1:0] exp_rd;
    bit            exp_err;
    ch      = model_ch(a);
    exp_oh  = '0;
    exp_we  = '0;
    if (ch < 0) begin
      lat     = 1;
      exp_rd  = 8'hFF;
      exp_err = 1'b1;
    end else begin
      lat     = int'(m_wait[ch]) + 2;
      exp_oh  = CH'(1) << ch;
      exp_rd  = ch_rdata[ch*DW +: DW];
      exp_err = w && m_ro[ch];
      if (w && !m_ro[ch]) exp_we = exp_oh;
    end
    cpu_req     = 1'b1;
    cpu_we      = w;
    cpu_address = a;
    cpu_wdata   = d;
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clock);
      n++;
      if (cpu_ready === 1'b1) begin
        got = 1'b1;
      end else begin
        chk("ch_sel_during", 32'(ch_sel), 32'(exp_oh));
        chk("ch_we_during", 32'(ch_we), (n == 1) ? 32'(exp_we) : 32'd0);
        if (ch >= 0) begin
          chk("ch_address", 32'(ch_address), 32'(a));
          chk("ch_wdata", 32'(ch_wdata), 32'(d));
        end
        if (wiggle) begin
          cpu_address = AW'($urandom);
          cpu_we      = 1'($urandom);
          cpu_wdata   = DW'($urandom);
        end
      end
    end
    if (!got) begin
      chk("ready_timeout", 32'(cpu_ready), 32'd1);
    end else begin
      chk("latency", 32'(n), 32'(lat));
      chk("rdata", 32'(cpu_rdata), 32'(exp_rd));
      chk("err", 32'(cpu_err), 32'(exp_err));
      chk("ch_sel_done", 32'(ch_sel), 32'd0);
    end
    cpu_req = hold;
    @(negedge clock);
    chk("gap_ready", 32'(cpu_ready), 32'd0);
    chk("gap_err", 32'(cpu_err), 32'd0);
    chk("gap_sel", 32'(ch_sel), 32'd0);
    chk("rdata_hold", 32'(cpu_rdata), 32'(exp_rd));
  endtask

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 4))
      0:       return AW'(32'hF0000 | ($urandom & 32'h1FFF));
      1:       return AW'(32'hB8000 | ($urandom & 32'h1FFF));
      2:       return AW'($urandom & 32'h3FFFF);
      3:       return AW'($urandom & 32'h0FFF);
      default: return AW'($urandom);
    endcase
  endfunction

  initial begin
    resetn      = 1'b0;
    cpu_req     = 1'b0;
    cpu_we      = 1'b0;
    cpu_address = '0;
    cpu_wdata   = '0;
    ch_rdata    = {8'hEA, 8'h5A, 8'h33, 8'h11};

    repeat (2) @(negedge clock);
    chk("rst_ready", 32'(cpu_ready), 32'd0);
    chk("rst_err", 32'(cpu_err), 32'd0);
    chk("rst_rdata", 32'(cpu_rdata), 32'hFF);
    chk("rst_sel", 32'(ch_sel), 32'd0);
    chk("rst_we", 32'(ch_we), 32'd0);
    chk("rst_addr", 32'(ch_address), 32'd0);
    chk("rst_wdata", 32'(ch_wdata), 32'd0);
    resetn = 1'b1;
    @(negedge clock);

    run_txn(20'h01234, 1'b0, 8'h00, 1'b0, 1'b0);   // ch2, 2 cycles, 5A
    run_txn(20'hF0010, 1'b0, 8'h00, 1'b0, 1'b0);   // ch3 read, 3 cycles, EA
    run_txn(20'hF0010, 1'b1, 8'h77, 1'b0, 1'b0);   // ch3 write suppressed, err
    run_txn(20'hB8000, 1'b1, 8'h41, 1'b0, 1'b0);   // ch1 write strobe
    run_txn(20'h80000, 1'b0, 8'h00, 1'b0, 1'b0);   // unmapped
    run_txn(20'h00ABC, 1'b0, 8'h00, 1'b0, 1'b0);   // ch0 beats overlapping ch2

    for (int k = 0; k < 6; k++) begin
      ch_rdata = $urandom;
      run_txn((k % 2 == 0) ? 20'h01234 : 20'hB8001, 1'($urandom), DW'($urandom), 1'b1, 1'b1);
    end

    // Reset in the middle of a waited access.
    ch_rdata = {8'hEA, 8'h5A, 8'h33, 8'h11};
    cpu_req     = 1'b1;
    cpu_we      = 1'b0;
    cpu_address = 20'hF0020;
    @(negedge clock);
    chk("pre_reset_sel", 32'(ch_sel), 32'h8);
    resetn = 1'b0;
    #1;
    chk("mid_rst_sel", 32'(ch_sel), 32'd0);
    chk("mid_rst_ready", 32'(cpu_ready), 32'd0);
    chk("mid_rst_rdata", 32'(cpu_rdata), 32'hFF);
    chk("mid_rst_addr", 32'(ch_address), 32'd0);
    cpu_req = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("rst_no_ready", 32'(cpu_ready), 32'd0);
    end
    resetn = 1'b1;
    @(negedge clock);
    run_txn(20'hF0020, 1'b0, 8'h00, 1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      ch_rdata = $urandom;
      run_txn(rand_addr(), 1'($urandom), DW'($urandom), 1'($urandom), 1'($urandom));
    end

    cpu_req = 1'b0;
    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
